dp_alu_stage: RTL and testbench
===============================

# dp_alu_stage

Execute-stage ALU for ARM data-processing instructions, sitting directly downstream of the operand-2 shifter. Consumes the shifted operand and shifter carry-out plus the Rn value, evaluates one of the 16 data-processing opcodes, and registers the result, destination, and write-enable toward writeback. Owns the NZCV flag register. Uses a valid/ready handshake on both sides, with 1-cycle latency.

## Interface
- No parameters; widths are fixed at 32-bit data and 4-bit register index.
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream operand bundle valid
- in_ready  out  1  stage can accept this cycle
- opcode  in  4  ARM DP opcode (AND=0 … MVN=15)
- s_bit  in  1  update flags
- rn_value  in  32  first operand
- operand2  in  32  shifter output
- shifter_carry  in  1  shifter carry-out
- rd_addr  in  4  destination register
- out_valid  out  1  result register holds valid op
- out_ready  in  1  downstream accepts
- result  out  32  registered ALU result
- rd_out  out  4  registered destination
- wb_en  out  1  result must be written (0 for TST/TEQ/CMP/CMN)
- nzcv  out  4  current flag register {N,Z,C,V}

## Operation
- Accept occurs when in_valid && in_ready. The result is computed combinationally from inputs and the current nzcv, then captured into the output register on that edge.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - C ← shifter_carry.
  - V unchanged.
- Arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN):
  - Computed as a 33-bit sum A + ~B/B + cin.
  - C = bit 32; for subtracts, C means NOT borrow.
  - V = signed overflow of the 32-bit operands.
  - ADC/SBC/RSC use the flag-register C as it stands at the accept edge.
- N = result[31]; Z = (result == 0).
- Flags are written on the accept edge only if s_bit = 1. TST/TEQ/CMP/CMN always write flags regardless of s_bit.
- The flag update is visible to the next accepted op with no bubble.
- wb_en = 0 for opcodes 8–11, else 1.
- Output register holds its contents while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, result=0, rd_out=0, wb_en=0, nzcv=0000.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 op per cycle while out_ready=1.
- Without skid: in_ready = !out_valid || out_ready (combinational).
- Simultaneous drain and accept: the output register is replaced and out_valid stays 1.
- out_valid falls after a drain with no accept.
- Payload outputs are stable while out_valid && !out_ready.
- Reset asserted mid-operation:
  - In-flight result is discarded.
  - Flags are cleared in the same edge.
  - No accept occurs in a reset cycle.
- Flags never change except on an accept edge or reset.

## Configuration
- DP_ALU_SKID_EN defined:
  - Adds a 1-entry skid buffer, so in_ready is a flop: in_ready = skid empty.
  - On accept while out stalls, the bundle is held in the skid. The flag computation is deferred to the moment the op is evaluated, so flag ordering stays in program order.
  - The skid drains into the output register when out_ready is high.
  - Reset empties the skid.
  - Latency is unchanged when not stalled.
- Undefined: the combinational in_ready described above applies; no skid storage.

## Structure
- Shared package dp_pkg:
  - Opcode localparams (OP_AND … OP_MVN).
  - NZCV bit indices.
  - Typedef for the operand bundle {opcode, s_bit, rn_value, operand2, shifter_carry, rd_addr}.
- One sub-module, dp_alu_core: purely combinational.
  - Inputs: opcode, operands, c_in, shifter_carry.
  - Outputs: result, n, z, c, v, wb_en.
- The top holds the handshake, the output register, the flag register, and the optional skid.

## Test plan
- ADDS 0xFFFFFFFF + 0x00000001, s_bit=1 → result 0x00000000, nzcv=0110, wb_en=1, one cycle later.
- CMP 5 vs 5 → wb_en=0, nzcv=0110. Then back-to-back ADC 1+1 → result 3 (C from the previous op), with no bubble.
- SUBS 0x80000000 − 1 → result 0x7FFFFFFF, nzcv=0011.
- MOVS operand2=0, shifter_carry=1, prior V=1 → result 0, nzcv=0111 (V preserved).
- Backpressure: out_ready=0 for 3 cycles with in_valid=1.
  - Without skid: in_ready=0 after the first accept.
  - With DP_ALU_SKID_EN: exactly 2 ops are held, outputs are stable, and no op is lost on release.
- Reset asserted one cycle after accepting ADDS → out_valid=0, nzcv=0000 the next cycle, no result emitted.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the ARM data-processing execute stage: opcodes,
// NZCV bit positions, the operand bundle and opcode-class helpers.
package dp_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        s_bit;
    logic [31:0] rn_value;
    logic [31:0] operand2;
    logic        shifter_carry;
    logic [3:0]  rd_addr;
  } dp_bundle_t;

  function automatic logic is_arith(input logic [3:0] op);
    logic r;
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // TST/TEQ/CMP/CMN: flags only, never written back
  function automatic logic is_compare(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/dp_alu_core.sv
// Combinational ARM data-processing ALU: one 33-bit adder shared by all
// arithmetic opcodes plus the logical unit, producing result and raw flags.
module dp_alu_core
  import dp_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [31:0] rn_value,
  input  logic [31:0] operand2,
  input  logic        c_in,
  input  logic        shifter_carry,
  output logic [31:0] result,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v,
  output logic        wb_en
);

  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        cin_s;
  logic [32:0] sum_s;
  logic [31:0] logic_s;

  // Adder operand selection; subtracts use A + ~B + cin so C is NOT borrow
  always_comb begin
    a_s   = rn_value;
    b_s   = operand2;
    cin_s = 1'b0;
    case (opcode)
      OP_SUB, OP_CMP: begin b_s = ~operand2; cin_s = 1'b1; end
      OP_RSB: begin a_s = operand2; b_s = ~rn_value; cin_s = 1'b1; end
      OP_ADC: cin_s = c_in;
      OP_SBC: begin b_s = ~operand2; cin_s = c_in; end
      OP_RSC: begin a_s = operand2; b_s = ~rn_value; cin_s = c_in; end
      default: cin_s = 1'b0;
    endcase
  end

  assign sum_s = {1'b0, a_s} + {1'b0, b_s} + {32'd0, cin_s};

  // Logical unit
  always_comb begin
    logic_s = 32'd0;
    case (opcode)
      OP_AND, OP_TST: logic_s = rn_value & operand2;
      OP_EOR, OP_TEQ: logic_s = rn_value ^ operand2;
      OP_ORR:         logic_s = rn_value | operand2;
      OP_MOV:         logic_s = operand2;
      OP_BIC:         logic_s = rn_value & ~operand2;
      OP_MVN:         logic_s = ~operand2;
      default:        logic_s = 32'd0;
    endcase
  end

  // Result and C/V select; V is only meaningful for arithmetic opcodes
  always_comb begin
    result = 32'd0;
    c      = 1'b0;
    v      = 1'b0;
    if (is_arith(opcode)) begin
      result = sum_s[31:0];
      c      = sum_s[32];
      v      = (a_s[31] == b_s[31]) && (sum_s[31] != a_s[31]);
    end else begin
      result = logic_s;
      c      = shifter_carry;
      v      = 1'b0;
    end
  end

  assign n     = result[31];
  assign z     = (result == 32'd0);
  assign wb_en = !is_compare(opcode);

endmodule

// File: rtl/dp_alu_stage.sv
// Execute stage: valid/ready handshake, output register and NZCV register
// around dp_alu_core. Define DP_ALU_SKID_EN for a 1-entry input skid buffer.
module dp_alu_stage
  import dp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic        s_bit,
  input  logic [31:0] rn_value,
  input  logic [31:0] operand2,
  input  logic        shifter_carry,
  input  logic [3:0]  rd_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  rd_out,
  output logic        wb_en,
  output logic [3:0]  nzcv
);

  dp_bundle_t  in_bundle_s;
  dp_bundle_t  eval_bundle_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        load_s;
  logic [31:0] core_result_s;
  logic        core_n_s, core_z_s, core_c_s, core_v_s, core_wb_s;
  logic        flag_we_s;
  logic [3:0]  nzcv_next_s;

  logic        out_valid_r;
  logic [31:0] result_r;
  logic [3:0]  rd_r;
  logic        wb_r;
  logic [3:0]  nzcv_r;

  assign in_bundle_s = {opcode, s_bit, rn_value, operand2, shifter_carry, rd_addr};

`ifdef DP_ALU_SKID_EN
  logic       skid_valid_r;
  dp_bundle_t skid_bundle_r;
  logic       out_free_s;

  assign out_free_s    = !out_valid_r || out_ready;
  assign in_ready_s    = !reset && !skid_valid_r;
  assign accept_s      = in_valid && in_ready_s;
  // A skidded op is evaluated only when it moves out, keeping flags in order
  assign eval_bundle_s = skid_valid_r ? skid_bundle_r : in_bundle_s;
  assign load_s        = out_free_s && (skid_valid_r || accept_s);

  // Skid entry: filled on accept into a stalled output, emptied on drain
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_r  <= 1'b0;
      skid_bundle_r <= '0;
    end else if (accept_s && !out_free_s) begin
      skid_valid_r  <= 1'b1;
      skid_bundle_r <= in_bundle_s;
    end else if (skid_valid_r && out_free_s) begin
      skid_valid_r  <= 1'b0;
    end
  end
`else
  assign in_ready_s    = !reset && (!out_valid_r || out_ready);
  assign accept_s      = in_valid && in_ready_s;
  assign eval_bundle_s = in_bundle_s;
  assign load_s        = accept_s;
`endif

  dp_alu_core u_core (
    .opcode        (eval_bundle_s.opcode),
    .rn_value      (eval_bundle_s.rn_value),
    .operand2      (eval_bundle_s.operand2),
    .c_in          (nzcv_r[NZCV_C]),
    .shifter_carry (eval_bundle_s.shifter_carry),
    .result        (core_result_s),
    .n             (core_n_s),
    .z             (core_z_s),
    .c             (core_c_s),
    .v             (core_v_s),
    .wb_en         (core_wb_s)
  );

  assign flag_we_s = load_s && (eval_bundle_s.s_bit || is_compare(eval_bundle_s.opcode));

  // Next flag value; logical ops leave V untouched
  always_comb begin
    nzcv_next_s         = nzcv_r;
    nzcv_next_s[NZCV_N] = core_n_s;
    nzcv_next_s[NZCV_Z] = core_z_s;
    nzcv_next_s[NZCV_C] = core_c_s;
    if (is_arith(eval_bundle_s.opcode)) begin
      nzcv_next_s[NZCV_V] = core_v_s;
    end else begin
      nzcv_next_s[NZCV_V] = nzcv_r[NZCV_V];
    end
  end

  // Output register: load on evaluation, clear valid on drain, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      rd_r        <= 4'd0;
      wb_r        <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      result_r    <= core_result_s;
      rd_r        <= eval_bundle_s.rd_addr;
      wb_r        <= core_wb_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_r <= 4'b0000;
    end else if (flag_we_s) begin
      nzcv_r <= nzcv_next_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign rd_out    = rd_r;
  assign wb_en     = wb_r;
  assign nzcv      = nzcv_r;

endmodule

// File: tb/tb_dp_alu_stage.sv
// Self-checking bench for dp_alu_stage: directed ARM flag cases, backpressure,
// reset, then randomized traffic against an arithmetic reference model.
module tb_dp_alu_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [31:0] rn_value;
  logic [31:0] operand2;
  logic        shifter_carry;
  logic [3:0]  rd_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  rd_out;
  logic        wb_en;
  logic [3:0]  nzcv;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wb;
    logic [3:0]  f;
  } exp_t;

  exp_t       q[$];
  logic [3:0] flags;
  logic       last_acc;

  always #5 clk = ~clk;

  dp_alu_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .s_bit         (s_bit),
    .rn_value      (rn_value),
    .operand2      (operand2),
    .shifter_carry (shifter_carry),
    .rd_addr       (rd_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .rd_out        (rd_out),
    .wb_en         (wb_en),
    .nzcv          (nzcv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: x op y with carry/borrow done in 64-bit integer arithmetic
  function automatic void arith(input logic [31:0] x, input logic [31:0] y, input bit sub,
                                input bit cb, output logic [31:0] r, output logic c,
                                output logic v);
    longint u;
    longint s;
    if (sub) begin
      u = longint'(x) - longint'(y) - longint'(cb);
      s = longint'($signed(x)) - longint'($signed(y)) - longint'(cb);
      c = (u >= 0);
    end else begin
      u = longint'(x) + longint'(y) + longint'(cb);
      s = longint'($signed(x)) + longint'($signed(y)) + longint'(cb);
      c = (u > 64'sd4294967295);
    end
    r = u[31:0];
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic void model(input logic [3:0] op, input logic s, input logic [31:0] a,
                                input logic [31:0] b, input logic sc, input logic [3:0] fi,
                                output logic [31:0] r, output logic wb, output logic [3:0] fo);
    logic c, v, cin;
    cin = fi[1];
    c = sc;
    v = fi[0];
    r = 32'd0;
    case (op)
      4'd0, 4'd8:  r = a & b;
      4'd1, 4'd9:  r = a ^ b;
      4'd12:       r = a | b;
      4'd13:       r = b;
      4'd14:       r = a & ~b;
      4'd15:       r = ~b;
      4'd2, 4'd10: arith(a, b, 1'b1, 1'b0, r, c, v);
      4'd3:        arith(b, a, 1'b1, 1'b0, r, c, v);
      4'd4, 4'd11: arith(a, b, 1'b0, 1'b0, r, c, v);
      4'd5:        arith(a, b, 1'b0, cin, r, c, v);
      4'd6:        arith(a, b, 1'b1, !cin, r, c, v);
      default:     arith(b, a, 1'b1, !cin, r, c, v);
    endcase
    wb = !(op >= 4'd8 && op <= 4'd11);
    fo = (s || !wb) ? {r[31], (r == 32'd0), c, v} : fi;
  endfunction

  // One clock: predict handshake, update the model, check outputs after the edge
  task automatic tick();
    logic        exp_rdy, acc, drn, w;
    logic [31:0] r;
    logic [3:0]  f;
    #1;
`ifdef DP_ALU_SKID_EN
    exp_rdy = !reset && (q.size() < 2);
`else
    exp_rdy = !reset && (q.size() == 0 || out_ready);
`endif
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = in_valid && exp_rdy;
    drn = (q.size() > 0) && out_ready;
    last_acc = acc;
    if (reset) begin
      q.delete();
      flags = 4'd0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        model(opcode, s_bit, rn_value, operand2, shifter_carry, flags, r, w, f);
        q.push_back('{r, rd_addr, w, f});
        flags = f;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("result", result, q[0].res);
      chk("rd_out", 32'(rd_out), 32'(q[0].rd));
      chk("wb_en", 32'(wb_en), 32'(q[0].wb));
    end
    chk("nzcv", 32'(nzcv), 32'((q.size() == 2) ? q[0].f : flags));
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic sc, input logic [3:0] rd);
    in_valid = 1'b1;
    opcode = op;
    s_bit = s;
    rn_value = a;
    operand2 = b;
    shifter_carry = sc;
    rd_addr = rd;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] x;
    case ($urandom_range(0, 4))
      0: x = 32'h0000_0000;
      1: x = 32'hFFFF_FFFF;
      2: x = 32'h8000_0000;
      3: x = 32'h7FFF_FFFF;
      default: x = $urandom;
    endcase
    return x;
  endfunction

  task automatic rand_op();
    drive(4'($urandom_range(0, 15)), 1'($urandom), pick(), pick(), 1'($urandom),
          4'($urandom_range(0, 15)));
  endtask

  initial begin
    flags = 4'd0;
    last_acc = 1'b0;
    reset = 1'b1;
    out_ready = 1'b1;
    drive(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_nzcv", 32'(nzcv), 32'd0);

    // ADDS 0xFFFFFFFF + 1
    drive(4'd4, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd3);
    tick();
    chk("adds_result", result, 32'd0);
    chk("adds_nzcv", 32'(nzcv), 32'h6);
    chk("adds_wb_en", 32'(wb_en), 32'd1);
    // CMP 5,5 then ADC 1+1 back to back
    drive(4'd10, 1'b0, 32'd5, 32'd5, 1'b0, 4'd4);
    tick();
    chk("cmp_wb_en", 32'(wb_en), 32'd0);
    chk("cmp_nzcv", 32'(nzcv), 32'h6);
    drive(4'd5, 1'b0, 32'd1, 32'd1, 1'b0, 4'd5);
    tick();
    chk("adc_result", result, 32'd3);
    // SUBS 0x80000000 - 1
    drive(4'd2, 1'b1, 32'h8000_0000, 32'd1, 1'b0, 4'd6);
    tick();
    chk("subs_result", result, 32'h7FFF_FFFF);
    chk("subs_nzcv", 32'(nzcv), 32'h3);
    // MOVS 0 with shifter carry; V from SUBS must survive
    drive(4'd13, 1'b1, 32'h1234_5678, 32'd0, 1'b1, 4'd7);
    tick();
    chk("movs_result", result, 32'd0);
    chk("movs_nzcv", 32'(nzcv), 32'h7);

    // Backpressure: drain, then 3 stalled cycles with in_valid held high
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    rand_op();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_acc) rand_op();
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset one cycle after an accepted ADDS
    drive(4'd4, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd9);
    tick();
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_nzcv", 32'(nzcv), 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Randomized traffic; a bundle not yet accepted stays on the inputs
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || last_acc) begin
        rand_op();
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
